ram_wide_read_streamer: RTL and testbench

RAM_WIDE_READ_STREAMER -- requirements
Module: ram_wide_read_streamer

---
 rtl/ram_wide_read_streamer.sv | 114 +++++++++++
 tb/tb_ram_wide_read_streamer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram_wide_read_streamer.sv
// ram_wide_read_streamer
//   Streams a burst of consecutive wide words out of a synchronous-read RAM
//   port onto a valid/ready stream. A 2-entry skid FIFO absorbs the one-cycle
//   RAM latency, so back-pressure never loses or duplicates a word.
// Ports
//   clk, rst              clock, async active-high reset
//   start                 burst request, sampled only in IDLE
//   base_addr, num_words  burst start address / length (0..2^ADDRWIDTHB)
//   busy, done            burst in progress / one-cycle completion pulse
//   enaB, addrB, doB      RAM read port (doB valid the cycle after enaB)
//   m_valid, m_data,      output stream
//   m_ready
module ram_wide_read_streamer #(
  parameter int WIDTHB     = 64,
  parameter int ADDRWIDTHB = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDRWIDTHB-1:0] base_addr,
  input  logic [ADDRWIDTHB:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  enaB,
  output logic [ADDRWIDTHB-1:0] addrB,
  input  logic [WIDTHB-1:0]     doB,
  output logic                  m_valid,
  output logic [WIDTHB-1:0]     m_data,
  input  logic                  m_ready
);

  localparam logic [ADDRWIDTHB:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, stateNext;

  logic [ADDRWIDTHB-1:0]      baseQ;
  logic [ADDRWIDTHB:0]        numQ, rdCnt, acCnt;
  logic                       inFlight;
  logic [1:0][WIDTHB-1:0]     fifoMem;
  logic                       wrPtr, rdPtr;
  logic [1:0]                 fifoCnt;
  logic                       issue, pop, lastIssue, lastAccept;

  // Occupancy plus the read already in flight must leave room for one more.
  assign issue      = (state == READ) && (rdCnt != numQ) &&
                      ((fifoCnt + {1'b0, inFlight}) < 2'd2);
  assign lastIssue  = issue && ((rdCnt + ONE) == numQ);
  assign enaB       = issue;
  assign addrB      = baseQ + rdCnt[ADDRWIDTHB-1:0];
  assign busy       = (state != IDLE);

  // Stream head is the FIFO head, or the RAM word arriving this cycle when the
  // FIFO is empty. That word is still written to the FIFO at the next edge;
  // if it is accepted now, the read pointer advances past it in the same edge.
  assign m_valid    = (fifoCnt != 2'd0) || inFlight;
  assign m_data     = (fifoCnt != 2'd0) ? fifoMem[rdPtr] :
                      (inFlight ? doB : '0);
  assign pop        = m_valid && m_ready;
  assign lastAccept = (state == DRAIN) && pop && ((acCnt + ONE) == numQ);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start && (num_words != '0)) stateNext = READ;
      READ:    if (lastIssue)                  stateNext = DRAIN;
      DRAIN:   if (lastAccept)                 stateNext = IDLE;
      default:                                 stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      baseQ    <= '0;
      numQ     <= '0;
      rdCnt    <= '0;
      acCnt    <= '0;
      inFlight <= 1'b0;
      fifoMem  <= '0;
      wrPtr    <= 1'b0;
      rdPtr    <= 1'b0;
      fifoCnt  <= 2'd0;
    end else begin
      state    <= stateNext;
      done     <= ((state == IDLE) && start && (num_words == '0)) || lastAccept;
      inFlight <= issue;

      if ((state == IDLE) && start) begin
        baseQ <= base_addr;
        numQ  <= num_words;
        rdCnt <= '0;
        acCnt <= '0;
      end else begin
        if (issue) rdCnt <= rdCnt + ONE;
        if (pop)   acCnt <= acCnt + ONE;
      end

      if (inFlight) begin
        fifoMem[wrPtr] <= doB;
        wrPtr          <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;

      case ({inFlight, pop})
        2'b10:   fifoCnt <= fifoCnt + 2'd1;
        2'b01:   fifoCnt <= fifoCnt - 2'd1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wide_read_streamer.sv
// Bench for ram_wide_read_streamer: a RAM model, a burst-level reference
// model with a per-cycle compare loop, and directed bursts with literal pins.
module tb_ram_wide_read_streamer;
  localparam int W  = 64;
  localparam int AW = 8;

  logic          clk = 0, rst, start, busy, done, enaB, m_valid, m_ready;
  logic [AW-1:0] base_addr, addrB;
  logic [AW:0]   num_words;
  logic [W-1:0]  doB, m_data;

  ram_wide_read_streamer #(.WIDTHB(W), .ADDRWIDTHB(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .enaB(enaB),
    .addrB(addrB), .doB(doB), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ramVal(input logic [AW-1:0] a);
    return {a, 48'h5A5A_1234_0000, ~a};
  endfunction

  // Synchronous-read RAM; junk on doB when not read so stale data shows up.
  always @(posedge clk)
    doB <= enaB ? ramVal(addrB) : 64'hBADB_ADBA_DBAD_BAD0;

  int            checks = 0, errors = 0;
  int            doneCnt = 0, xferCnt = 0;
  logic [AW-1:0] enaLog[$];

  task automatic chk(input string name, input logic ok,
                     input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: per accepted burst, the expected stream is
  // RAM[base+k mod 2^AW] for k<num; done follows the last transfer by a cycle.
  task automatic monitorLoop();
    int cyc = 0, doneDue = -1, validDue = -1, rdCnt = 0, eNum = 0;
    logic mBusy = 0, wasBusy, holdPrev = 0;
    logic [AW-1:0] eBase = 0, expA;
    logic [W-1:0] prevData = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rstOut", {busy, done, enaB, m_valid} == 4'b0 && addrB == '0 && m_data == '0,
            {busy, done, enaB, m_valid, addrB, m_data[7:0]}, '0);
        mBusy = 0; doneDue = -1; validDue = -1; holdPrev = 0;
        continue;
      end
      wasBusy = mBusy;
      chk("busy", busy == mBusy, busy, mBusy);
      chk("done", done == (cyc == doneDue), done, cyc == doneDue);
      if (done) doneCnt++;
      if (enaB) begin
        expA = eBase + AW'(rdCnt);
        chk("enaInBurst", mBusy && rdCnt < eNum, rdCnt, eNum);
        chk("addrB", addrB == expA, addrB, expA);
        enaLog.push_back(addrB);
        rdCnt++;
        chk("outstanding", (rdCnt - xferCnt) <= 2, rdCnt - xferCnt, 2);
      end
      if (m_valid && !mBusy) chk("validIdle", 1'b0, m_valid, 0);
      if (cyc == validDue) chk("firstValid", m_valid, m_valid, 1);
      if (holdPrev) chk("holdStable", m_valid && m_data == prevData, m_data, prevData);
      holdPrev = m_valid && !m_ready;
      prevData = m_data;
      if (m_valid && m_ready && mBusy) begin
        expA = eBase + AW'(xferCnt);
        chk("data", m_data == ramVal(expA), m_data, ramVal(expA));
        xferCnt++;
        if (xferCnt == eNum) begin mBusy = 0; doneDue = cyc + 1; end
      end
      if (start && !wasBusy) begin
        eBase = base_addr; eNum = int'(num_words); rdCnt = 0; xferCnt = 0;
        if (eNum > 0) begin mBusy = 1; validDue = cyc + 2; end
        else doneDue = cyc + 1;
      end
    end
  endtask

  task automatic doStart(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk); #1;
    start = 1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic waitDone(input int bound);
    int d = doneCnt;
    for (int i = 0; i < bound && doneCnt == d; i++) @(posedge clk);
    #1;
    chk("doneSeen", doneCnt == d + 1, doneCnt, d + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, d0;
    logic [AW-1:0] e029[4], e030[4], e031[4];
    logic [255:0] seen;
    e029 = '{8'h10, 8'h11, 8'h12, 8'h13};
    e030 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    e031 = '{8'h20, 8'h21, 8'h22, 8'h23};
    rst = 1; start = 0; base_addr = 0; num_words = 0; m_ready = 1;
    fork monitorLoop(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Basic 4-word burst
    n0 = enaLog.size(); d0 = doneCnt;
    doStart(8'h10, 9'd4);
    waitDone(40);
    chk("b029cnt", enaLog.size() - n0 == 4, enaLog.size() - n0, 4);
    for (int i = 0; i < 4 && n0 + i < enaLog.size(); i++)
      chk("b029addr", enaLog[n0+i] == e029[i], enaLog[n0+i], e029[i]);

    // Address wrap
    n0 = enaLog.size();
    doStart(8'hFE, 9'd4);
    waitDone(40);
    for (int i = 0; i < 4 && n0 + i < enaLog.size(); i++)
      chk("b030addr", enaLog[n0+i] == e030[i], enaLog[n0+i], e030[i]);

    // Zero-length burst
    n0 = enaLog.size();
    doStart(8'h33, 9'd0);
    waitDone(10);
    chk("b032noEna", enaLog.size() == n0, enaLog.size(), n0);

    // Back-pressure, plus an ignored start mid-burst
    n0 = enaLog.size();
    m_ready = 0;
    doStart(8'h20, 9'd4);
    doStart(8'h40, 9'd2);
    repeat (8) @(posedge clk);
    #1;
    chk("b031ena2", enaLog.size() - n0 == 2, enaLog.size() - n0, 2);
    chk("b031valid", m_valid == 1'b1, m_valid, 1);
    chk("b031head", m_data == 64'h205A5A12340000DF, m_data, 64'h205A5A12340000DF);
    m_ready = 1;
    waitDone(40);
    chk("b031cnt", enaLog.size() - n0 == 4, enaLog.size() - n0, 4);
    for (int i = 0; i < 4 && n0 + i < enaLog.size(); i++)
      chk("b031addr", enaLog[n0+i] == e031[i], enaLog[n0+i], e031[i]);

    // Reset mid-burst, then a normal burst
    doStart(8'h50, 9'd6);
    for (int i = 0; i < 50 && xferCnt < 2; i++) @(negedge clk);
    chk("b033reach2", xferCnt >= 2, xferCnt, 2);
    @(posedge clk); #1 rst = 1;
    d0 = doneCnt;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("b033noDone", doneCnt == d0, doneCnt, d0);
    chk("b033idle", busy == 1'b0 && m_valid == 1'b0, {busy, m_valid}, 0);
    doStart(8'h60, 9'd3);
    waitDone(40);

    // Full-depth burst with random back-pressure
    n0 = enaLog.size(); d0 = doneCnt;
    m_ready = 1'($urandom_range(0, 1));
    doStart(8'h00, 9'h100);
    for (int i = 0; i < 3000 && doneCnt == d0; i++) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("b034done1", doneCnt == d0 + 1, doneCnt, d0 + 1);
    chk("b034ena", enaLog.size() - n0 == 256, enaLog.size() - n0, 256);
    seen = '0;
    for (int i = n0; i < enaLog.size(); i++) seen[enaLog[i]] = 1'b1;
    chk("b034cover", &seen, seen[63:0], 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
